dma_streamer: RTL

//  Burst splitter between dma_fsm and the AXI master I/F; one instance per direction (IS_WR).
//  On stream valid from dma_fsm it latches the descriptor address/length and issues an

---
 rtl/dma_pkg.sv | 44 ++++
 rtl/dma_streamer.sv | 119 +++++++++++
 2 files changed

// File: rtl/dma_pkg.sv
// Shared DMA types: streamer FSM states, error report struct and the burst sizing helper.
package dma_pkg;

    localparam int DMA_ADDR_W = 32;
    localparam int AXI_BOUND  = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_REQ,
        ST_DONE,
        ST_ERR,
        ST_HOLD
    } dma_strm_st_t;

    typedef enum logic [1:0] {
        DMA_ERR_NONE = 2'd0,
        DMA_ERR_RD   = 2'd1,
        DMA_ERR_WR   = 2'd2
    } dma_err_src_e;

    typedef struct packed {
        logic                  valid;
        dma_err_src_e          src;
        logic [DMA_ADDR_W-1:0] addr;
    } s_dma_error_t;

    // Largest legal INCR burst from addr: capped by remaining beats, max burst and the
    // distance to the next bound-aligned address. bound must be a power of 2.
    function automatic logic [8:0] dma_burst_beats(input logic [63:0] rem,
                                                   input logic [63:0] addr,
                                                   input int unsigned db_log2,
                                                   input int unsigned max_beats,
                                                   input int unsigned bound);
        logic [63:0] room;
        logic [63:0] n;
        room = (64'(bound) - (addr & (64'(bound) - 64'd1))) >> db_log2;
        n    = rem;
        if (n > 64'(max_beats)) n = 64'(max_beats);
        if (n > room)           n = room;
        return n[8:0];
    endfunction

endpackage

// File: rtl/dma_streamer.sv
// Splits one DMA descriptor into an ordered series of AXI INCR burst requests,
// respecting the max-beat and address-boundary limits.
module dma_streamer
    import dma_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int BYTES_W    = 32,
    parameter int DATA_BYTES = 8,
    parameter int MAX_BEATS  = 256,
    parameter int BOUND      = AXI_BOUND,
    parameter bit IS_WR      = 1'b0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               stream_vld_i,
    input  logic [ADDR_W-1:0]  desc_addr_i,
    input  logic [BYTES_W-1:0] desc_bytes_i,
    output logic               stream_done_o,
    output s_dma_error_t       stream_err_o,
    output logic               req_vld_o,
    input  logic               req_rdy_i,
    output logic [ADDR_W-1:0]  req_addr_o,
    output logic [7:0]         req_len_o,
    output logic [2:0]         req_size_o,
    output logic               req_last_o
);

    localparam int DB_LOG2 = $clog2(DATA_BYTES);
    localparam logic [BYTES_W:0] DB_M1 = (BYTES_W+1)'(DATA_BYTES - 1);
    localparam dma_err_src_e ERR_SRC = IS_WR ? DMA_ERR_WR : DMA_ERR_RD;

    dma_strm_st_t       state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BYTES_W:0]   rem_q;
    logic [8:0]         beats_q;
    logic               last_q;
    logic               req_vld_q;
    logic               done_q;
    s_dma_error_t       err_q;

    logic [BYTES_W:0]   rem_init_d;
    logic [8:0]         beats_d;
    logic               misaligned_d;

    // Extra top bit keeps the round-up from overflowing at max num_bytes.
    assign rem_init_d   = ({1'b0, desc_bytes_i} + DB_M1) >> DB_LOG2;
    assign beats_d      = dma_burst_beats(64'(rem_q), 64'(addr_q), DB_LOG2, MAX_BEATS, BOUND);
    assign misaligned_d = desc_addr_i[DB_LOG2-1:0] != '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            beats_q   <= '0;
            last_q    <= 1'b0;
            req_vld_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            done_q       <= 1'b0;
            err_q.valid  <= 1'b0;
            case (state_q)
                ST_IDLE: if (stream_vld_i) begin
                    addr_q <= desc_addr_i;
                    rem_q  <= rem_init_d;
                    if (misaligned_d) begin
                        state_q     <= ST_ERR;
                        err_q.valid <= 1'b1;
                        err_q.src   <= ERR_SRC;
                        err_q.addr  <= DMA_ADDR_W'(desc_addr_i);
                        done_q      <= 1'b1;
                    end else if (desc_bytes_i == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (!stream_vld_i) begin
                        state_q <= ST_HOLD;
                    end else begin
                        beats_q   <= beats_d;
                        last_q    <= (BYTES_W+1)'(beats_d) == rem_q;
                        req_vld_q <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: if (req_rdy_i) begin
                    req_vld_q <= 1'b0;
                    addr_q    <= addr_q + (ADDR_W'(beats_q) << DB_LOG2);
                    rem_q     <= rem_q - (BYTES_W+1)'(beats_q);
                    if (last_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else if (!stream_vld_i) begin
                        state_q <= ST_HOLD;
                    end else begin
                        state_q <= ST_CALC;
                    end
                end
                ST_DONE, ST_ERR: state_q <= ST_HOLD;
                // The fsm still drives valid for a cycle after done; don't relaunch on it.
                ST_HOLD: if (!stream_vld_i) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stream_done_o = done_q;
    assign stream_err_o  = err_q;
    assign req_vld_o     = req_vld_q;
    assign req_addr_o    = addr_q;
    assign req_len_o     = 8'(beats_q - 9'd1);
    assign req_size_o    = 3'(DB_LOG2);
    assign req_last_o    = last_q;

endmodule
